// File: rtl/vga_tile_engine.sv
// vga_tile_engine
//   VGA timing generator and tile renderer. Stage 0 runs the pixel/line
//   counters and tracks the tile position incrementally, without any
//   division. Stage 1 forms the tile RAM address and the active/sync
//   flags. Stage 2 registers the colour and sync outputs, so a pixel at
//   stage-0 (hc,vc) reaches the pins exactly two pix_ce ticks later.
//
//   Optional feature: define VGA_GRID_EN to overlay a white 1-pixel grid
//   on the first column and first row of every tile.
//
// Ports
//   vgaclk      system clock
//   rst         asynchronous active-high reset
//   pix_ce      pixel-rate clock enable; nothing advances while low
//   tile_addr   tile RAM read address (row*TILES_X + col), held outside
//               the active area
//   tile_data   {R,G,B} returned by the tile RAM, one vgaclk after tile_addr
//   hc / vc     stage-0 pixel and line counters
//   frame_start high for the pix_ce period in which stage-0 sits at (0,0)
//   de          data enable, aligned with the RGB outputs
//   hsync/vsync sync outputs, asserted level given by SYNC_POL
//   red/green/blue  colour channels, COLOR_W bits each
module vga_tile_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int TILE_W   = 40,
  parameter int TILE_H   = 40,
  parameter int COLOR_W  = 4,
  localparam int TILES_X = H_ACTIVE / TILE_W,
  localparam int TILES_Y = V_ACTIVE / TILE_H,
  localparam int ADDR_W  = $clog2(TILES_X * TILES_Y)
) (
  input  logic                   vgaclk,
  input  logic                   rst,
  input  logic                   pix_ce,
  output logic [ADDR_W-1:0]      tile_addr,
  input  logic [3*COLOR_W-1:0]   tile_data,
  output logic [9:0]             hc,
  output logic [9:0]             vc,
  output logic                   frame_start,
  output logic                   de,
  output logic                   hsync,
  output logic                   vsync,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sized copies of the timing constants so every compare is 10 bits wide.
  localparam logic [9:0] HC_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] TX_LAST = 10'(TILE_W - 1);
  localparam logic [9:0] TY_LAST = 10'(TILE_H - 1);
  localparam logic [15:0] ROW_STEP = 16'(TILES_X);

  // Stage-0 tile tracking state.
  logic [9:0]  tx_sub;
  logic [9:0]  tx;
  logic [9:0]  ty_sub;
  logic [15:0] row_base;

  // Cleared by reset; the first pix_ce afterwards only sets it, so stage 0
  // spends a full pix_ce period at (0,0) with frame_start raised.
  logic run;

  // Stage-1 registers.
  logic active1;
  logic hs1;
  logic vs1;
`ifdef VGA_GRID_EN
  logic grid1;
`endif

  // Stage 0: raster counters plus the incremental tile column/row tracking.
  // tx/row_base keep counting through blanking; they are only consumed
  // while the pixel is active, and both clear when their counter wraps.
  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      tx_sub      <= '0;
      tx          <= '0;
      ty_sub      <= '0;
      row_base    <= '0;
      run         <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      if (!run) begin
        run         <= 1'b1;
        frame_start <= 1'b1;
      end else begin
        frame_start <= 1'b0;
        if (hc == HC_LAST) begin
          hc     <= '0;
          tx_sub <= '0;
          tx     <= '0;
          if (vc == VC_LAST) begin
            vc          <= '0;
            ty_sub      <= '0;
            row_base    <= '0;
            frame_start <= 1'b1;
          end else begin
            vc <= vc + 10'd1;
            if (ty_sub == TY_LAST) begin
              ty_sub   <= '0;
              row_base <= row_base + ROW_STEP;
            end else begin
              ty_sub <= ty_sub + 10'd1;
            end
          end
        end else begin
          hc <= hc + 10'd1;
          if (tx_sub == TX_LAST) begin
            tx_sub <= '0;
            tx     <= tx + 10'd1;
          end else begin
            tx_sub <= tx_sub + 10'd1;
          end
        end
      end
    end
  end

  // Stage 1: tile address and raster flags. Gated by run so the restart
  // tick after reset does not inject a duplicate (0,0) pixel. The address
  // only moves inside the active area so the RAM sees a stable index
  // during blanking.
  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      tile_addr <= '0;
      active1   <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
`ifdef VGA_GRID_EN
      grid1     <= 1'b0;
`endif
    end else if (pix_ce && run) begin
      if ((hc < H_ACT) && (vc < V_ACT)) begin
        tile_addr <= ADDR_W'(row_base + 16'(tx));
      end
      active1 <= (hc < H_ACT) && (vc < V_ACT);
      hs1     <= (hc >= HS_BEG) && (hc <= HS_END);
      vs1     <= (vc >= VS_BEG) && (vc <= VS_END);
`ifdef VGA_GRID_EN
      grid1   <= (tx_sub == 10'd0) || (ty_sub == 10'd0);
`endif
    end
  end

  // Stage 2: output registers. tile_data here belongs to the address
  // issued by stage 1 on the previous pix_ce tick.
  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      de    <= 1'b0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_ce) begin
      de    <= active1;
      hsync <= hs1 ? SYNC_POL : ~SYNC_POL;
      vsync <= vs1 ? SYNC_POL : ~SYNC_POL;
      if (!active1) begin
        {red, green, blue} <= '0;
`ifdef VGA_GRID_EN
      end else if (grid1) begin
        {red, green, blue} <= '1;
`endif
      end else begin
        {red, green, blue} <= tile_data;
      end
    end
  end

endmodule
